qd_debounced_edge_pio: RTL and testbench
========================================

Name: qd_debounced_edge_pio

Overview:
- Parametrised Avalon-MM input PIO for push-buttons and switches; successor to the fixed 4-bit any-edge push PIO.
- Adds three things per input bit:
  - 2-FF synchroniser and debounce filter driven by a shared tick prescaler.
  - Programmable rising/falling edge selection.
  - Write-1-to-clear edge capture, with irq masking.
- Sits between board button pins and the Nios interconnect, one instance per button/switch bank.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- TICK_DIV, 50000, clk cycles per debounce tick (>=1; 1 = tick every cycle).
- STABLE_TICKS, 10, consecutive ticks a changed level must persist before acceptance (1..255).
- RESET_LEVEL, 0, WIDTH-bit value loaded into sync and debounced registers at reset (use all-ones for active-low buttons).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous pin inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt request

Behaviour:
- Reset is applied asynchronously with reset_n low: clk and reset_n behave as already decided (reset reset_n, asynchronous, active-low; clock clk). Reset values:
  - readdata=0, irq=0.
  - Sync stages and debounced register = RESET_LEVEL.
  - irq_mask, rise_en, fall_en, edge_capture all 0.
  - Prescaler and all stability counters 0.
- Synchroniser: s1<=in_port, s2<=s1. Only s2 is used downstream.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 for one cycle when count==TICK_DIV-1.
  - Runs continuously from reset.
- Per-bit debounce, bit i, cnt[i] is 8 bits:
  - If s2[i]==deb[i]: cnt[i]<=0, on every clk.
  - Else on tick: if cnt[i]==STABLE_TICKS-1, then deb[i]<=s2[i] and cnt[i]<=0; otherwise cnt[i]++.
  - Else with no tick: hold.
  - Any cycle of equality restarts the count. A glitch that returns before the next tick is never seen.
- Edge detect:
  - rise[i] = deb[i] & ~deb_d[i] & rise_en[i].
  - fall[i] = ~deb[i] & deb_d[i] & fall_en[i].
  - deb_d is deb delayed one cycle, reset to RESET_LEVEL.
  - With both enables set, any edge is captured. With neither set, no capture.
- edge_capture[i]:
  - Set when rise[i]|fall[i].
  - Cleared when a write to address 3 has writedata[i]=1.
  - Set and clear in the same cycle: set wins, so no edge is lost.
  - Bits written 0 are unaffected.
- irq = |(edge_capture & irq_mask), combinational from registers.
  - Changing irq_mask while capture bits are set takes effect on irq the next cycle.
- Register map. Unused upper bits read 0 and write-ignore.

  | Addr | Register | Access |
  |---|---|---|
  | 0 | deb | RO |
  | 1 | s2 (raw synchronised) | RO |
  | 2 | irq_mask | RW |
  | 3 | edge_capture | RO / W1C |
  | 4 | rise_en | RW |
  | 5 | fall_en | RW |
  | 6, 7 | none | read 0, writes ignored |

- Writes to addresses 0 and 1 are ignored.
- Read latency: readdata is registered every clk from address. It is valid the cycle after address is presented, and it does not depend on chipselect.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0.
- Mid-operation reset (reset_n low): returns every register to its reset value immediately, including a debounce in progress. No edge is generated on reset release, because deb_d equals deb.

Test Plan:
All cases use WIDTH=4, TICK_DIV=4, STABLE_TICKS=3, RESET_LEVEL=0.
1. Reset: hold reset_n low, drive in_port=4'hF. Required: readdata=0 and irq=0 throughout; after release, address 0 reads 0 until debounce completes.
2. Debounce acceptance: set rise_en=4'h1, irq_mask=4'h1, then raise in_port[0] and hold. Required:
   - deb[0]=1 after 2 sync cycles plus 3 ticks (within 14 clks).
   - edge_capture=4'h1 one cycle later, then irq=1.
   - Reading address 3 returns 32'h1.
3. Glitch rejection: pulse in_port[1] high for 5 clks, then low. Required: deb stays 0, edge_capture stays 0, irq stays 0.
4. Edge selection: fall_en=4'h2 and rise_en=0. Raise in_port[1] and settle: no capture. Lower it and settle: edge_capture=4'h2.
5. W1C and collision:
   - With edge_capture=4'h3, write 4'h1 to address 3. Required: edge_capture=4'h2.
   - Then time a W1C of bit 1 on the same cycle that a new bit-1 edge is detected. Required: bit 1 remains 1.
6. Mask and unmapped addresses: edge_capture=4'h4, irq_mask=0 gives irq=0. Write irq_mask=4'h4: irq=1 the next cycle. Reads of addresses 6 and 7 return 32'h0.

Source files
------------

// File: rtl/qd_debounced_edge_pio.sv
// Avalon-MM input PIO: per-bit 2-FF synchroniser, tick-based debounce,
// selectable rising/falling edge capture (W1C) and masked level interrupt.
module qd_debounced_edge_pio #(
  parameter int unsigned      WIDTH        = 4,
  parameter int unsigned      TICK_DIV     = 50000,
  parameter int unsigned      STABLE_TICKS = 10,
  parameter logic [WIDTH-1:0] RESET_LEVEL  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned     PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0]      CNT_LAST   = 8'(STABLE_TICKS - 1);

  // Bus: single-cycle Avalon-MM slave with no wait states. A write commits on
  // the edge where chipselect=1 and write_n=0; readdata reflects the register
  // selected by address one cycle later, independent of chipselect.

  logic [WIDTH-1:0]      s1_q, s1_d;
  logic [WIDTH-1:0]      s2_q, s2_d;
  logic [WIDTH-1:0]      deb_q, deb_d;
  logic [WIDTH-1:0]      deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0][7:0] cnt_q, cnt_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [WIDTH-1:0]      irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]      rise_en_q, rise_en_d;
  logic [WIDTH-1:0]      fall_en_q, fall_en_d;
  logic [WIDTH-1:0]      edge_cap_q, edge_cap_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  tick;
  logic                  wr_en;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      edge_hit;
  logic [WIDTH-1:0]      w1c;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);

    s1_d      = in_port;
    s2_d      = s1_q;
    deb_d     = deb_q;
    cnt_d     = cnt_q;
    deb_dly_d = deb_q;

    // Any cycle of agreement restarts the count, so only a level that
    // disagrees across STABLE_TICKS consecutive ticks is accepted.
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    wr_en    = chipselect & ~write_n;
    wdata    = writedata[WIDTH-1:0];
    edge_hit = (deb_q & ~deb_dly_q & rise_en_q) | (~deb_q & deb_dly_q & fall_en_q);
    w1c      = (wr_en && address == 3'd3) ? wdata : '0;

    // Set is OR-ed in after the clear so a colliding new edge is kept.
    edge_cap_d = (edge_cap_q & ~w1c) | edge_hit;
    irq_mask_d = (wr_en && address == 3'd2) ? wdata : irq_mask_q;
    rise_en_d  = (wr_en && address == 3'd4) ? wdata : rise_en_q;
    fall_en_d  = (wr_en && address == 3'd5) ? wdata : fall_en_q;

    readdata_d = '0;
    case (address)
      3'd0:    readdata_d = 32'(deb_q);
      3'd1:    readdata_d = 32'(s2_q);
      3'd2:    readdata_d = 32'(irq_mask_q);
      3'd3:    readdata_d = 32'(edge_cap_q);
      3'd4:    readdata_d = 32'(rise_en_q);
      3'd5:    readdata_d = 32'(fall_en_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q       <= RESET_LEVEL;
      s2_q       <= RESET_LEVEL;
      deb_q      <= RESET_LEVEL;
      deb_dly_q  <= RESET_LEVEL;
      cnt_q      <= '0;
      presc_q    <= '0;
      irq_mask_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      irq_mask_q <= irq_mask_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_qd_debounced_edge_pio.sv
// Bench for qd_debounced_edge_pio: directed scenarios plus random stimulus,
// read data checked through an expected queue against a behavioural model.
module tb_qd_debounced_edge_pio;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int ST = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [W-1:0] in_port = '0;
  logic [31:0] readdata;
  logic        irq;
  logic        rd_req = 1'b0;

  always #5 clk = ~clk;

  qd_debounced_edge_pio #(
    .WIDTH(W), .TICK_DIV(TD), .STABLE_TICKS(ST), .RESET_LEVEL(4'h0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each input bit is accepted once the synchronised level has disagreed with
  // the accepted level for ST whole tick events in a row; ticks fall on every
  // TD-th clock after reset. Edge capture is a sticky set of enabled edges.
  logic [W-1:0] m_s1, m_s2, m_deb, m_prev, m_mask, m_rise, m_fall, m_cap;
  int           m_run [W];
  int           m_cyc;
  logic         pend;
  logic [31:0]  exp_q [$];
  logic [31:0]  m_rv;
  logic [W-1:0] m_hit, m_clr;
  logic         m_tick;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
      m_mask = '0; m_rise = '0; m_fall = '0; m_cap = '0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
      m_cyc = 0;
      pend = 1'b0;
      exp_q.delete();
    end else begin
      case (address)
        3'd0: m_rv = 32'(m_deb);
        3'd1: m_rv = 32'(m_s2);
        3'd2: m_rv = 32'(m_mask);
        3'd3: m_rv = 32'(m_cap);
        3'd4: m_rv = 32'(m_rise);
        3'd5: m_rv = 32'(m_fall);
        default: m_rv = 32'h0;
      endcase
      pend = rd_req;
      if (rd_req) exp_q.push_back(m_rv);

      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      m_hit = (m_deb & ~m_prev & m_rise) | (~m_deb & m_prev & m_fall);
      m_clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
      m_cap = (m_cap & ~m_clr) | m_hit;
      if (chipselect && !write_n) begin
        if (address == 3'd2) m_mask = writedata[W-1:0];
        if (address == 3'd4) m_rise = writedata[W-1:0];
        if (address == 3'd5) m_fall = writedata[W-1:0];
      end
      m_prev = m_deb;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          if (m_tick) begin
            m_run[i]++;
            if (m_run[i] == ST) begin
              m_deb[i] = m_s2[i];
              m_run[i] = 0;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = in_port;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_readdata", readdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
    end else begin
      check("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
      if (pend) begin
        check("rd_queue_nonempty", 32'(exp_q.size() > 0), 32'h1);
        if (exp_q.size() > 0) check("readdata", readdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a);
    address = a; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic read_check(input logic [2:0] a, input string name, input logic [31:0] exp);
    bus_read(a);
    check(name, readdata, exp);
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    int r;

    // Reset with all pins high: nothing visible until debounce completes.
    in_port = 4'hF;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    read_check(3'd0, "deb_after_reset", 32'h0);
    read_check(3'd0, "deb_still_filtering", 32'h0);
    idle(20);
    read_check(3'd0, "deb_settled_high", 32'hF);
    in_port = 4'h0;
    idle(20);
    read_check(3'd0, "deb_settled_low", 32'h0);
    read_check(3'd3, "no_capture_disabled", 32'h0);

    // Debounce acceptance and rising capture.
    bus_write(3'd4, 32'h1);
    bus_write(3'd2, 32'h1);
    in_port[0] = 1'b1;
    lat = 0;
    do begin
      bus_read(3'd0);
      lat++;
    end while (!readdata[0] && lat < 40);
    check("deb_latency_le14", 32'((lat - 1) <= 14), 32'h1);
    idle(2);
    check("irq_after_rise", {31'b0, irq}, 32'h1);
    read_check(3'd3, "capture_rise0", 32'h1);

    // Glitch rejection.
    bus_write(3'd3, 32'hF);
    in_port[1] = 1'b1;
    idle(5);
    in_port[1] = 1'b0;
    idle(20);
    read_check(3'd0, "glitch_deb", 32'h1);
    read_check(3'd3, "glitch_capture", 32'h0);
    check("glitch_irq", {31'b0, irq}, 32'h0);

    // Edge selection: falling only on bit 1.
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h2);
    in_port[1] = 1'b1;
    idle(20);
    read_check(3'd3, "rise_ignored", 32'h0);
    in_port[1] = 1'b0;
    idle(20);
    read_check(3'd3, "fall_captured", 32'h2);

    // W1C of one bit, then a clear colliding with a new edge.
    bus_write(3'd5, 32'h3);
    in_port[0] = 1'b0;
    idle(20);
    read_check(3'd3, "capture_both", 32'h3);
    bus_write(3'd3, 32'h1);
    read_check(3'd3, "w1c_bit0", 32'h2);
    bus_write(3'd4, 32'h2);
    in_port[1] = 1'b1;
    n = 0;
    while (!(m_deb[1] ^ m_prev[1]) && n < 40) begin
      idle(1);
      n++;
    end
    check("collision_in_time", 32'(n < 40), 32'h1);
    bus_write(3'd3, 32'h2);
    read_check(3'd3, "collision_set_wins", 32'h2);

    // Mask control and unmapped addresses.
    bus_write(3'd3, 32'hF);
    bus_write(3'd2, 32'h0);
    bus_write(3'd4, 32'h4);
    in_port[2] = 1'b1;
    idle(20);
    read_check(3'd3, "capture_bit2", 32'h4);
    check("irq_masked", {31'b0, irq}, 32'h0);
    bus_write(3'd2, 32'h4);
    check("irq_unmasked", {31'b0, irq}, 32'h1);
    read_check(3'd6, "addr6_zero", 32'h0);
    read_check(3'd7, "addr7_zero", 32'h0);
    bus_write(3'd0, 32'hF);
    bus_write(3'd1, 32'h0);
    read_check(3'd0, "deb_write_ignored", 32'h6);
    read_check(3'd2, "mask_readback", 32'h4);

    // Randomised traffic with a reset in the middle.
    for (int it = 0; it < 1200; it++) begin
      if (it == 600) begin
        in_port = 4'($urandom);
        apply_reset($urandom_range(1, 4));
      end
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        in_port = in_port ^ 4'($urandom_range(1, 15));
        idle($urandom_range(1, 20));
      end else if (r <= 5) begin
        bus_write(3'($urandom_range(0, 7)), $urandom);
      end else if (r <= 8) begin
        bus_read(3'($urandom_range(0, 7)));
      end else begin
        idle(1);
      end
    end

    idle(5);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
